// File: rtl/bcd_digit_converter.sv
// Iterative shift-and-add-3 binary-to-BCD converter; o_done IN_W+1 cycles after an accepted start.
// Back-to-back starts are accepted in the DONE cycle; i_start is ignored while busy, with no queueing.
module bcd_digit_converter #(
    parameter int IN_W   = 14,
    parameter int DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [IN_W-1:0]       i_value,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_digits,
    output logic                  o_overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(IN_W - 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IN_W-1:0] shift_q;
    logic [BW-1:0]   bcd_q;
    logic [CW-1:0]   cnt_q;
    logic            ovf_q;

    logic            load;
    logic            step;
    logic            last;
    logic [63:0]     value_ext;
    logic            value_ovf;
    logic [BW-1:0]   bcd_adj;
    logic [BW-1:0]   bcd_next;
    logic [IN_W-1:0] shift_next;

    assign value_ext = 64'(i_value);
    assign value_ovf = (value_ext > MAX_VAL);
    assign last      = (cnt_q == LAST);

    // Nibbles >= 5 get +3 so the following doubling carries correctly into the next digit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // The bit shifted out of the top digit is dropped, leaving value mod 10^DIGITS.
    assign bcd_next   = {bcd_adj[BW-2:0], shift_q[IN_W-1]};
    assign shift_next = shift_q << 1;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = CONV;
                    load    = 1'b1;
                end
            end
            CONV: begin
                o_busy = 1'b1;
                step   = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
                if (i_start) begin
                    state_d = CONV;
                    load    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            o_digits   <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (load) begin
                shift_q <= i_value;
                bcd_q   <= '0;
                cnt_q   <= '0;
                ovf_q   <= value_ovf;
            end else if (step) begin
                shift_q <= shift_next;
                bcd_q   <= bcd_next;
                cnt_q   <= cnt_q + CW'(1);
            end
            // Results are published only on entry to DONE, so scratch values never leak out.
            if (step && last) begin
                o_digits   <= bcd_next;
                o_overflow <= ovf_q;
            end
        end
    end

endmodule

// File: tb/tb_bcd_digit_converter.sv
// Directed bench for bcd_digit_converter: a 14-bit/4-digit instance and an exhaustive 6-bit/2-digit instance.
module tb_bcd_digit_converter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] value;
    logic        busy;
    logic        done;
    logic [15:0] digits;
    logic        ovf;

    logic        s_start;
    logic [5:0]  s_value;
    logic        s_busy;
    logic        s_done;
    logic [7:0]  s_digits;
    logic        s_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_digit_converter #(.IN_W(14), .DIGITS(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_value    (value),
        .o_busy     (busy),
        .o_done     (done),
        .o_digits   (digits),
        .o_overflow (ovf)
    );

    bcd_digit_converter #(.IN_W(6), .DIGITS(2)) dut_small (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (s_start),
        .i_value    (s_value),
        .o_busy     (s_busy),
        .o_done     (s_done),
        .o_digits   (s_digits),
        .o_overflow (s_ovf)
    );

    // Start is accepted on the next rising edge; the input value is scrambled right after capture.
    task automatic apply_start(input logic [13:0] v);
        @(negedge clk);
        start = 1'b1;
        value = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        value = 14'h3FFF;
    endtask

    // cycles counts rising edges with the accepting edge as 1; bounded so a missing done ends the wait.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles      = 1;
        busy_cycles = 0;
        while (!done && cycles < 100) begin
            busy_cycles += int'(busy);
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        value   = '0;
        s_start = 1'b0;
        s_value = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, digits, ovf} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b digits=%h ovf=%0b, want all 0", busy, done, digits, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%0b done=%0b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int c, b;
        apply_start(14'd1234);
        wait_done(c, b);
        checks++;
        if (c !== 15) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, want 15", c);
        end
        checks++;
        if (b !== 14) begin
            errors++;
            $display("FAIL basic_busy: got %0d busy cycles, want 14", b);
        end
        checks++;
        if (digits !== 16'h1234 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got %h ovf=%0b, want 1234 ovf=0", digits, ovf);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || digits !== 16'h1234) begin
            errors++;
            $display("FAIL basic_hold: got done=%0b digits=%h, want done=0 digits=1234", done, digits);
        end
    endtask

    task automatic test_edge_values();
        int c, b;
        apply_start(14'd0);
        wait_done(c, b);
        checks++;
        if (c !== 15 || digits !== 16'h0000 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL zero: got cycles=%0d digits=%h ovf=%0b, want 15 0000 0", c, digits, ovf);
        end
        apply_start(14'd9999);
        wait_done(c, b);
        checks++;
        if (c !== 15 || digits !== 16'h9999 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL max9999: got cycles=%0d digits=%h ovf=%0b, want 15 9999 0", c, digits, ovf);
        end
    endtask

    task automatic test_overflow();
        int c, b;
        apply_start(14'd10000);
        wait_done(c, b);
        checks++;
        if (digits !== 16'h0000 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_10000: got digits=%h ovf=%0b, want 0000 1", digits, ovf);
        end
        apply_start(14'd16383);
        wait_done(c, b);
        checks++;
        if (digits !== 16'h6383 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_16383: got digits=%h ovf=%0b, want 6383 1", digits, ovf);
        end
    endtask

    task automatic test_ignore_start();
        int c, b, extra;
        apply_start(14'd1234);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        value = 14'd42;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(c, b);
        checks++;
        if (c !== 10 || digits !== 16'h1234) begin
            errors++;
            $display("FAIL ignore_start: got cycles=%0d digits=%h, want 10 1234", c, digits);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            extra += int'(done);
        end
        checks++;
        if (extra !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_single_done: got %0d extra dones busy=%0b, want 0 0", extra, busy);
        end
    endtask

    task automatic test_back_to_back();
        int c, b;
        apply_start(14'd4321);
        wait_done(c, b);
        checks++;
        if (c !== 15 || digits !== 16'h4321) begin
            errors++;
            $display("FAIL b2b_first: got cycles=%0d digits=%h, want 15 4321", c, digits);
        end
        start = 1'b1;
        value = 14'd56;
        @(posedge clk);
        #1;
        start = 1'b0;
        value = 14'h3FFF;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%0b, want 1", busy);
        end
        wait_done(c, b);
        checks++;
        if (c !== 15 || digits !== 16'h0056 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got cycles=%0d digits=%h ovf=%0b, want 15 0056 0", c, digits, ovf);
        end
    endtask

    task automatic test_reset_mid();
        int c, b, seen;
        apply_start(14'd16383);
        wait_done(c, b);
        apply_start(14'd1234);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, digits, ovf} !== 19'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%0b done=%0b digits=%h ovf=%0b, want all 0", busy, done, digits, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            seen += int'(done) + int'(busy);
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midreset_no_done: got %0d done/busy cycles, want 0", seen);
        end
        apply_start(14'd9876);
        wait_done(c, b);
        checks++;
        if (c !== 15 || digits !== 16'h9876 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL midreset_restart: got cycles=%0d digits=%h ovf=%0b, want 15 9876 0", c, digits, ovf);
        end
    endtask

    task automatic test_small_exhaustive();
        int c;
        logic [7:0] exp;
        for (int v = 0; v < 64; v++) begin
            exp = {4'(v / 10), 4'(v % 10)};
            @(negedge clk);
            s_start = 1'b1;
            s_value = 6'(v);
            @(posedge clk);
            #1;
            s_start = 1'b0;
            c = 1;
            while (!s_done && c < 50) begin
                @(posedge clk);
                #1;
                c++;
            end
            checks++;
            if (c !== 7 || s_digits !== exp || s_ovf !== 1'b0) begin
                errors++;
                $display("FAIL small_%0d: got cycles=%0d digits=%h ovf=%0b, want 7 %h 0", v, c, s_digits, s_ovf, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edge_values();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_small_exhaustive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog expired");
    end

endmodule
